alu_ctrl_mc: RTL and testbench
==============================

Name: alu_ctrl_mc

Overview:
Parametrised successor to the single-cycle ALU control decoder for the MIPS core. It keeps the combinational op/funct to ALU-control decode and shamt-source select. It adds an iterative multi-cycle unit for MULT/MULTU/DIV/DIVU with HI/LO registers, a valid/ready issue handshake, and a pipeline stall output. It sits between the main control unit and the ALU/HI-LO writeback path.

Parameters:
DATA_W, 32, operand and HI/LO width; must be even, >=8.
OP_W, 4, width of the ALU op field from main control.
CTRL_W, 4, width of the ALU control code.
CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, localparam).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  op/funct/operands valid this cycle
in_ready  out  1  block can accept an instruction
op  in  OP_W  ALU op from main control
funct  in  6  R-type funct field
rs_val  in  DATA_W  operand A (dividend/multiplicand)
rt_val  in  DATA_W  operand B (divisor/multiplier)
control  out  CTRL_W  ALU control code (combinational)
mux_alu_src_regimm_shamt  out  1  select shamt as ALU B source (combinational)
hilo_sel  out  2  writeback source: 00 ALU, 01 HI, 10 LO
stall  out  1  hold upstream pipeline
hilo_we  out  1  one-cycle pulse when HI/LO updated
hi_out  out  DATA_W  HI register
lo_out  out  DATA_W  LO register
div_by_zero  out  1  sticky until next DIV/DIVU accept

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; hi_out=lo_out=0; hilo_we=0; div_by_zero=0; counter=0. Reset mid-operation aborts it with no HI/LO write. in_ready=1 and stall=0 in the cycle after reset.
- Decode (pure combinational, independent of state). Non-R ops map as: 0000->0010, 0001->0110, 0011->0000, 0101->0001, 0110->0111, 0100->0100.
- R-type (op=0010) funct mapping: 100000->0010, 100010->0110, 000000 sll->0011 with shamt=1, 000010 srl->0100 with shamt=1, 000100 sllv->0011 with shamt=0, 000110 srlv->0100 with shamt=0, 100100->0000, 100101->0001, 101010->0111.
- Also R-type: 010000 mfhi -> hilo_sel=01; 010010 mflo -> hilo_sel=10. Any other combination -> control=0000, shamt=0, hilo_sel=00.
- Multi-cycle funct codes: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU.
- State machine: IDLE -> MUL or DIV -> DONE -> IDLE.
- IDLE: in_ready=1. Accept = in_valid & in_ready & multi-cycle funct; on accept, latch operand magnitudes and sign flags, and set counter=DATA_W.
- MUL/DIV: one bit per cycle (shift-add multiply / restoring divide); counter decrements each cycle; leave when counter reaches 1.
- DONE: sign-correct the result; write HI/LO; hilo_we=1 for exactly this cycle.
- Latency: accept at cycle 0, hilo_we at cycle DATA_W+1, in_ready high again at cycle DATA_W+2.
- stall=1 from the accept cycle through DONE, and also when in_valid with mfhi/mflo arrives while state!=IDLE.
- Single-cycle ops never stall and never touch HI/LO. in_ready=0 outside IDLE.
- Product: {HI,LO} = full 2*DATA_W product; signed for MULT, unsigned for MULTU.
- Divide: LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
- Divide by zero (rt_val=0): no iteration; go directly to DONE next cycle; HI=rs_val, LO=all ones, div_by_zero=1.
- Signed overflow (most-negative / -1): LO=most-negative, HI=0, no flag.

Optional Feature:
ALU_DIV_EN. Defined: DIV/DIVU behave as above. Undefined: the DIV state and divider datapath are not compiled; DIV/DIVU decode as an unknown funct (control=0000, no stall, no HI/LO write) and div_by_zero ties to 0. MULT/MULTU are unaffected either way.

Decomposition:
- Package alu_ctrl_pkg: ALU control code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL), op and funct constants, hilo_sel constants, and the state enum typedef.
- One natural sub-module, alu_ctrl_decode, holding the purely combinational decode; alu_ctrl_mc instantiates it and adds the sequencer and datapath.

Test Plan:
- Decode sweep: op=0010 with each funct listed above, and op=0000..0110 -> control, shamt and hilo_sel exactly as tabulated; op=0010, funct=111111 -> control=0000, shamt=0.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> stall high cycles 0..33; hilo_we pulse at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; in_ready high at cycle 34.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 0 -> hilo_we at cycle 2, HI=100, LO=0xFFFFFFFF, div_by_zero=1.
- mfhi issued at cycle 5 of a MULT -> stall held and in_ready=0 until state is IDLE; hilo_sel=01; HI equals the new product.
- Assert rst_n=0 at cycle 10 of a DIVU -> next cycle state IDLE, HI=LO=0, no hilo_we pulse, in_ready=1.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU control codes, op/funct encodings, hilo_sel codes and sequencer states
package alu_ctrl_pkg;

  // ALU control codes driven to the ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU op field from main control
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_OR    = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;

  // Writeback source select
  localparam logic [1:0] HILO_ALU = 2'b00;
  localparam logic [1:0] HILO_HI  = 2'b01;
  localparam logic [1:0] HILO_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational op/funct decode (DIV/DIVU recognised only with ALU_DIV_EN)
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int CTRL_W = 4
) (
  input  logic [OP_W-1:0]   op,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] control,
  output logic              shamt_sel,
  output logic [1:0]        hilo_sel,
  output logic              is_mul,
  output logic              is_div,
  output logic              is_signed,
  output logic              is_mfhilo
);

  // Map op/funct to ALU control, shamt source, writeback source and multi-cycle class
  always_comb begin
    control   = '0;
    shamt_sel = 1'b0;
    hilo_sel  = HILO_ALU;
    is_mul    = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_mfhilo = 1'b0;
    if (op == OP_W'(OP_RTYPE)) begin
      case (funct)
        F_ADD:   control = CTRL_W'(ALU_ADD);
        F_SUB:   control = CTRL_W'(ALU_SUB);
        F_SLL:   begin control = CTRL_W'(ALU_SLL); shamt_sel = 1'b1; end
        F_SRL:   begin control = CTRL_W'(ALU_SRL); shamt_sel = 1'b1; end
        F_SLLV:  control = CTRL_W'(ALU_SLL);
        F_SRLV:  control = CTRL_W'(ALU_SRL);
        F_AND:   control = CTRL_W'(ALU_AND);
        F_OR:    control = CTRL_W'(ALU_OR);
        F_SLT:   control = CTRL_W'(ALU_SLT);
        F_MFHI:  begin hilo_sel = HILO_HI; is_mfhilo = 1'b1; end
        F_MFLO:  begin hilo_sel = HILO_LO; is_mfhilo = 1'b1; end
        F_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
        F_MULTU: is_mul = 1'b1;
`ifdef ALU_DIV_EN
        F_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
        F_DIVU:  is_div = 1'b1;
`endif
        default: ;
      endcase
    end else begin
      case (op)
        OP_W'(OP_ADD): control = CTRL_W'(ALU_ADD);
        OP_W'(OP_SUB): control = CTRL_W'(ALU_SUB);
        OP_W'(OP_AND): control = CTRL_W'(ALU_AND);
        OP_W'(OP_OR):  control = CTRL_W'(ALU_OR);
        OP_W'(OP_SLT): control = CTRL_W'(ALU_SLT);
        OP_W'(OP_SRL): control = CTRL_W'(ALU_SRL);
        default:       ;
      endcase
    end
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// rtl/alu_ctrl_mc.sv - ALU control decode plus iterative MULT/DIV unit with HI/LO; divider built only when ALU_DIV_EN is defined
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [CTRL_W-1:0] control,
  output logic              mux_alu_src_regimm_shamt,
  output logic [1:0]        hilo_sel,
  output logic              stall,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_by_zero
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic dec_is_mul, dec_is_div, dec_is_signed, dec_is_mfhilo;

  alu_ctrl_decode #(.OP_W(OP_W), .CTRL_W(CTRL_W)) u_decode (
    .op        (op),
    .funct     (funct),
    .control   (control),
    .shamt_sel (mux_alu_src_regimm_shamt),
    .hilo_sel  (hilo_sel),
    .is_mul    (dec_is_mul),
    .is_div    (dec_is_div),
    .is_signed (dec_is_signed),
    .is_mfhilo (dec_is_mfhilo)
  );

  state_e state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // acc_hi: partial product high half / partial remainder
  // acc_lo: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              neg_q, neg_d;

  logic              accept;
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0]   mul_sum;
  logic [2*DATA_W-1:0] prod;

`ifdef ALU_DIV_EN
  logic            div_q, div_d;
  logic            dz_q, dz_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dbz_q, dbz_d;
  logic [DATA_W:0] div_trial, div_diff;
`endif

  assign accept = in_valid && (state_q == ST_IDLE) && (dec_is_mul || dec_is_div);
  assign a_neg  = dec_is_signed && rs_val[DATA_W-1];
  assign b_neg  = dec_is_signed && rt_val[DATA_W-1];
  assign a_mag  = a_neg ? (~rs_val + 1'b1) : rs_val;
  assign b_mag  = b_neg ? (~rt_val + 1'b1) : rt_val;
  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, opb_q};
  assign prod    = {acc_hi_q, acc_lo_q};

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Sequencer next state: IDLE -> MUL/DIV -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec_is_div ? ST_DIV : ST_MUL;
      ST_MUL:  if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
`ifdef ALU_DIV_EN
      ST_DIV:  if (dz_q || (cnt_q == CNT_W'(1))) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake, stall and HI/LO write strobe from the current state
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    hilo_we  = (state_q == ST_DONE);
    stall    = accept || (state_q != ST_IDLE) ||
               (in_valid && dec_is_mfhilo && (state_q != ST_IDLE));
  end

  // Datapath next state: operand latch, one bit per cycle, sign-corrected writeback
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef ALU_DIV_EN
    div_d     = div_q;
    dz_d      = dz_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    div_trial = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_diff  = div_trial - {1'b0, opb_q};
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d    = CNT_W'(DATA_W);
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          opb_d    = b_mag;
          neg_d    = a_neg ^ b_neg;
`ifdef ALU_DIV_EN
          div_d     = dec_is_div;
          neg_rem_d = a_neg;
          dz_d      = 1'b0;
          if (dec_is_div) begin
            dbz_d = 1'b0;
            if (rt_val == '0) begin
              // Hold the raw dividend so it can be returned as HI
              dz_d     = 1'b1;
              acc_hi_d = rs_val;
            end
          end
`endif
        end
      end
      ST_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (acc_lo_q[0]) {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[DATA_W-1:1]};
        else             {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[DATA_W-1:1]};
      end
`ifdef ALU_DIV_EN
      ST_DIV: begin
        if (!dz_q) begin
          cnt_d    = cnt_q - 1'b1;
          // Restoring step: keep the subtraction only when it did not borrow
          acc_hi_d = div_diff[DATA_W] ? div_trial[DATA_W-1:0] : div_diff[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], ~div_diff[DATA_W]};
        end
      end
`endif
      ST_DONE: begin
`ifdef ALU_DIV_EN
        if (div_q) begin
          if (dz_q) begin
            hi_d  = acc_hi_q;
            lo_d  = '1;
            dbz_d = 1'b1;
          end else begin
            lo_d = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
            hi_d = neg_rem_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
          end
        end else
`endif
        {hi_d, lo_d} = neg_q ? (~prod + 1'b1) : prod;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything and aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef ALU_DIV_EN
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef ALU_DIV_EN
      div_q     <= div_d;
      dz_q      <= dz_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
`ifdef ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// tb/tb_alu_ctrl_mc.sv - directed self-checking bench for alu_ctrl_mc
module tb_alu_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  control;
  logic        shamt;
  logic [1:0]  hilo_sel;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi_out, lo_out;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_ctrl_mc dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_valid                 (in_valid),
    .in_ready                 (in_ready),
    .op                       (op),
    .funct                    (funct),
    .rs_val                   (rs_val),
    .rt_val                   (rt_val),
    .control                  (control),
    .mux_alu_src_regimm_shamt (shamt),
    .hilo_sel                 (hilo_sel),
    .stall                    (stall),
    .hilo_we                  (hilo_we),
    .hi_out                   (hi_out),
    .lo_out                   (lo_out),
    .div_by_zero              (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dec_chk(input logic [3:0] o, input logic [5:0] f,
                         input logic [3:0] c, input logic s, input logic [1:0] h);
    op = o; funct = f; #1;
    check($sformatf("decode op=%b f=%b", o, f), {control, shamt, hilo_sel}, {c, s, h});
  endtask

  // Issue at cycle 0 and follow to completion; done_cyc is the hilo_we cycle
  task automatic run_multi(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input int done_cyc);
    int bad;
    in_valid = 1'b1; op = 4'b0010; funct = f; rs_val = a; rt_val = b; #1;
    check({tag, " c0 stall/ready"}, {stall, in_ready}, 2'b11);
    next_cycle();
    in_valid = 1'b0;
    bad = 0;
    for (int c = 1; c < done_cyc; c++) begin
      #1;
      if (!(stall && !in_ready && !hilo_we)) bad++;
      next_cycle();
    end
    check({tag, " busy cycles"}, bad, 0);
    #1;
    check({tag, " done we/stall"}, {hilo_we, stall, in_ready}, 3'b110);
    next_cycle();
    #1;
    check({tag, " idle we/stall/ready"}, {hilo_we, stall, in_ready}, 3'b001);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; op = 4'b0000; funct = 6'b0; rs_val = '0; rt_val = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1; #1;
    check("reset ready/stall/we/dbz", {in_ready, stall, hilo_we, div_by_zero}, 4'b1000);
    check("reset hi/lo", {hi_out, lo_out}, 64'h0);

    // Decode sweep
    dec_chk(4'b0010, 6'b100000, 4'b0010, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b100010, 4'b0110, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b000000, 4'b0011, 1'b1, 2'b00);
    dec_chk(4'b0010, 6'b000010, 4'b0100, 1'b1, 2'b00);
    dec_chk(4'b0010, 6'b000100, 4'b0011, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b000110, 4'b0100, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b100100, 4'b0000, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b100101, 4'b0001, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b101010, 4'b0111, 1'b0, 2'b00);
    dec_chk(4'b0010, 6'b010000, 4'b0000, 1'b0, 2'b01);
    dec_chk(4'b0010, 6'b010010, 4'b0000, 1'b0, 2'b10);
    dec_chk(4'b0010, 6'b111111, 4'b0000, 1'b0, 2'b00);
    dec_chk(4'b0000, 6'b000000, 4'b0010, 1'b0, 2'b00);
    dec_chk(4'b0001, 6'b000000, 4'b0110, 1'b0, 2'b00);
    dec_chk(4'b0011, 6'b000000, 4'b0000, 1'b0, 2'b00);
    dec_chk(4'b0100, 6'b000000, 4'b0100, 1'b0, 2'b00);
    dec_chk(4'b0101, 6'b000000, 4'b0001, 1'b0, 2'b00);
    dec_chk(4'b0110, 6'b000000, 4'b0111, 1'b0, 2'b00);
    next_cycle();

    // MULT -3 * 7 = -21
    run_multi("mult", 6'b011000, 32'hFFFFFFFD, 32'h7, 33);
    check("mult hi/lo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    next_cycle();

    // MULTU max * max
    run_multi("multu", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    check("multu hi/lo", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
    next_cycle();

    // mfhi arriving mid-MULTU: 0x10000 * 0x30000 = 0x3_0000_0000
    in_valid = 1'b1; op = 4'b0010; funct = 6'b011001; rs_val = 32'h10000; rt_val = 32'h30000;
    next_cycle();
    in_valid = 1'b0;
    repeat (4) next_cycle();
    in_valid = 1'b1; funct = 6'b010000;
    bad = 0;
    for (int c = 5; c <= 33; c++) begin
      #1;
      if (!(stall && !in_ready && hilo_sel == 2'b01)) bad++;
      next_cycle();
    end
    check("mfhi held while busy", bad, 0);
    #1;
    check("mfhi at idle stall/ready/sel", {stall, in_ready, hilo_sel}, 4'b0101);
    check("mfhi sees new hi", hi_out, 32'h3);
    check("mfhi lo", lo_out, 32'h0);
    in_valid = 1'b0;
    next_cycle();

`ifdef ALU_DIV_EN
    // DIV -7 / 2
    run_multi("div", 6'b011010, 32'hFFFFFFF9, 32'h2, 33);
    check("div hi/lo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
    next_cycle();

    // DIVU 100 / 0
    run_multi("divu0", 6'b011011, 32'd100, 32'h0, 2);
    check("divu0 hi/lo", {hi_out, lo_out}, 64'h00000064_FFFFFFFF);
    check("divu0 flag", div_by_zero, 1'b1);
    next_cycle();

    // Overflow: most-negative / -1 also clears the sticky flag
    run_multi("divovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 33);
    check("divovf hi/lo", {hi_out, lo_out}, 64'h00000000_80000000);
    check("divovf flag", div_by_zero, 1'b0);
    next_cycle();
    funct = 6'b011011;
`else
    // Divider absent: DIV behaves as an unknown funct
    in_valid = 1'b1; op = 4'b0010; funct = 6'b011010; rs_val = 32'hFFFFFFF9; rt_val = 32'h0; #1;
    check("nodiv decode", {control, shamt, hilo_sel, stall}, 8'b0000_0_00_0);
    next_cycle();
    in_valid = 1'b0; #1;
    check("nodiv idle", {in_ready, hilo_we, stall, div_by_zero}, 4'b1000);
    check("nodiv hi/lo kept", {hi_out, lo_out}, 64'h00000003_00000000);
    next_cycle();
    funct = 6'b011001;
`endif

    // Reset at cycle 10 of a multi-cycle op aborts it
    in_valid = 1'b1; op = 4'b0010; rs_val = 32'd1000; rt_val = 32'd3;
    next_cycle();
    in_valid = 1'b0;
    repeat (8) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1; #1;
    check("abort ready/stall/we", {in_ready, stall, hilo_we}, 3'b100);
    check("abort hi/lo", {hi_out, lo_out}, 64'h0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (hilo_we || !in_ready || hi_out != 32'h0 || lo_out != 32'h0) bad++;
    end
    check("abort no late write", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
